memory_arbiter: RTL and testbench
=================================

// Module: memory_arbiter
// PURPOSE
//  Shares the single-ported RAM between the instruction-fetch and data requesters of the pipelined datapath.
//  Registered grant FSM: data side has priority, with a bounded-starvation guarantee for instruction fetch.
//  The RAM responds with a variable latency. This block forwards each transaction, raises per-side wait signals,
//  and returns the load word to the requester that holds the grant. Sits between the cache/datapath side and the RAM model.
// PARAMETERS
//  D_STREAK_MAX  4   consecutive data grants allowed while an instr request is pending (>=1)
//  ADDR_W        32  address width
//  DATA_W        32  word width
// PORTS
//  CLK       in   1       clock, all state on rising edge
//  RST       in   1       asynchronous reset, active-high
//  iREN      in   1       instruction read request (level, held until iwait==0)
//  iaddr     in   ADDR_W  instruction address
//  iwait     out  1       1 = instr request pending/not done; 0 on completion cycle or when idle
//  iload     out  DATA_W  instruction word, valid when iREN && !iwait
//  dREN      in   1       data read request (level)
//  dWEN      in   1       data write request (level); dREN&&dWEN -> treated as write
//  daddr     in   ADDR_W  data address
//  dstore    in   DATA_W  write data
//  dwait     out  1       1 = data request pending/not done
//  dload     out  DATA_W  data word, valid when dREN && !dwait
//  ramREN    out  1       RAM read strobe
//  ramWEN    out  1       RAM write strobe
//  ramaddr   out  ADDR_W  RAM address
//  ramstore  out  DATA_W  RAM write data
//  ramload   in   DATA_W  RAM read data, valid when ramstate==ACCESS
//  ramstate  in   2       FREE=0, BUSY=1, ACCESS=2, ERROR=3
//  memerr    out  1       sticky: RAM returned ERROR since reset
// BEHAVIOUR
//  States: IDLE, GNT_I, GNT_D. RST forces IDLE, dstreak=0, memerr=0 immediately.
//  IDLE: ramREN=ramWEN=0; ramaddr/ramstore=0; iwait=iREN; dwait=dREN|dWEN. Arbitration picks the next state:
//   - Data pending and (!iREN or dstreak<D_STREAK_MAX) -> GNT_D.
//   - Else iREN -> GNT_I.
//   - Else stay in IDLE.
//  GNT_I: ramREN=1, ramaddr=iaddr; iwait=1 until ramstate==ACCESS. In that cycle iwait=0 and iload=ramload
//   (combinational). Next state IDLE; dstreak<=0.
//  GNT_D: ramREN=dREN&!dWEN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore.
//   - On ACCESS: dwait=0, dload=ramload, next state IDLE.
//   - dstreak<=dstreak+1 (saturating) if iREN, else 0.
//  Non-granted side: wait=its request level; load outputs=0.
//  Minimum latency: 1 cycle of arbitration plus RAM latency. With ramstate==ACCESS on the first granted cycle,
//   completion occurs 1 cycle after the request is raised.
//  Request dropped while granted (neither REN nor WEN of the owner): abort, strobes 0 that cycle, next state IDLE,
//   dstreak unchanged.
//  ramstate==ERROR while granted: set memerr; wait stays 1; return to IDLE and re-arbitrate (retry). ERROR in IDLE is ignored.
//  Address/data change mid-grant: forwarded live. Requesters must hold inputs stable; the arbiter does not latch them.
//  One completion per grant. A requester that holds its request after completion is re-arbitrated from IDLE.
//  No RAM strobe is ever asserted in IDLE or during reset.
// TESTING
//  1 iREN=1 iaddr=0x40, RAM ACCESS after 2 BUSY cycles, ramload=0xDEADBEEF -> iwait=0 + iload=DEADBEEF in 4th cycle, then IDLE.
//  2 iREN=dWEN=1 same cycle, daddr=0x100 dstore=0x5 -> GNT_D first: ramWEN=1, ramstore=5. Then GNT_I.
//    Iwait stays 1 throughout the data transaction.
//  3 iREN held, dREN asserted continuously, ACCESS on every granted cycle ->
//    exactly 4 data completions, then 1 instr completion, then the pattern repeats.
//  4 GNT_D, ramstate=ERROR once, then ACCESS -> memerr=1 sticky, retry completes with dwait=0, strobes 0 in the IDLE cycle.
//  5 RST pulsed mid GNT_I (ramstate BUSY) -> ramREN=0 asynchronously, state IDLE, memerr=0, dstreak=0.
//  6 dREN dropped while GNT_D BUSY -> strobes 0 that cycle, IDLE next, no dload completion, pending iREN granted next.

Source files
------------

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-ported RAM between instruction fetch and data
// requesters. Data has priority, but after D_STREAK_MAX consecutive data grants
// taken while a fetch is waiting, the fetch is served next.
//
// Handshake: a requester raises its request level (iREN / dREN / dWEN) with stable
// address/data and holds it; its wait output stays 1 until the single cycle in which
// the RAM reports ACCESS for its grant. In that cycle wait=0 and the load word is
// valid. A request dropped while granted aborts the access with no completion.
module memory_arbiter #(
  parameter int D_STREAK_MAX = 4,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              memerr,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  localparam int             SW         = $clog2(D_STREAK_MAX + 1);
  localparam logic [SW-1:0]  STREAK_MAX = SW'(D_STREAK_MAX);

  state_t        r_state;
  logic [SW-1:0] r_dstreak;
  logic          r_memerr;

  logic w_d_req;
  logic w_i_live;
  logic w_d_live;
  logic w_i_done;
  logic w_d_done;
  logic w_err;
  logic w_streak_lt;

  // Grant-owner status: a grant is "live" only while its owner keeps requesting.
  always_comb begin
    w_d_req     = dREN | dWEN;
    w_i_live    = (r_state == GNT_I) && iREN;
    w_d_live    = (r_state == GNT_D) && w_d_req;
    w_i_done    = w_i_live && (ramstate == RS_ACCESS);
    w_d_done    = w_d_live && (ramstate == RS_ACCESS);
    w_err       = (w_i_live || w_d_live) && (ramstate == RS_ERROR);
    w_streak_lt = r_dstreak < STREAK_MAX;
  end

  // Grant FSM, data streak counter and sticky error flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= IDLE;
      r_dstreak <= '0;
      r_memerr  <= 1'b0;
    end else begin
      if (w_err) r_memerr <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_d_req && (!iREN || w_streak_lt)) r_state <= GNT_D;
          else if (iREN)                         r_state <= GNT_I;
        end
        GNT_I: begin
          // Abort and error both leave the streak alone; only a fetch completion clears it.
          if (!iREN || w_err) begin
            r_state <= IDLE;
          end else if (w_i_done) begin
            r_state   <= IDLE;
            r_dstreak <= '0;
          end
        end
        GNT_D: begin
          if (!w_d_req || w_err) begin
            r_state <= IDLE;
          end else if (w_d_done) begin
            r_state <= IDLE;
            if (!iREN)            r_dstreak <= '0;
            else if (w_streak_lt) r_dstreak <= r_dstreak + SW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // RAM strobes and requester wait/load outputs, decoded from the current grant.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = iREN;
    dwait    = w_d_req;
    iload    = '0;
    dload    = '0;
    case (r_state)
      GNT_I: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iwait   = iREN && !w_i_done;
        iload   = w_i_done ? ramload : '0;
      end
      GNT_D: begin
        ramREN   = dREN & ~dWEN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dwait    = w_d_req && !w_d_done;
        dload    = (w_d_done && !dWEN) ? ramload : '0;
      end
      default: ;
    endcase
  end

  assign memerr      = r_memerr;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed scenarios for the arbiter plus a randomized run
// against a behavioural RAM and a transaction-level reference of the memory contents
// and of the fetch-starvation bound.
module tb_memory_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int D_STREAK_MAX = 4;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  logic              CLK = 1'b0;
  logic              RST;
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              iwait;
  logic [DATA_W-1:0] iload;
  logic              dREN, dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              dwait;
  logic [DATA_W-1:0] dload;
  logic              ramREN, ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic [1:0]        ramstate;
  logic              memerr;
  logic [1:0]        o_dbg_state;

  int checks = 0;
  int failures = 0;

  memory_arbiter #(.D_STREAK_MAX(D_STREAK_MAX), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .memerr(memerr), .o_dbg_state(o_dbg_state)
  );

  // Clock and watchdog
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset();
    RST = 1'b1; iREN = 0; iaddr = '0; dREN = 0; dWEN = 0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = FREE;
    repeat (2) @(negedge CLK);
    #1;
    checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin failures++; $display("FAIL rst_strobes got=%0b%0b exp=00", ramREN, ramWEN); end
    checks++; if (iwait !== 1'b0 || dwait !== 1'b0) begin failures++; $display("FAIL rst_waits got=%0b%0b exp=00", iwait, dwait); end
    checks++; if (memerr !== 1'b0) begin failures++; $display("FAIL rst_memerr got=%0b exp=0", memerr); end
    checks++; if (o_dbg_state !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", o_dbg_state); end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_instr_fetch();
    @(negedge CLK); iREN = 1; iaddr = 32'h40; ramstate = FREE; #1;
    checks++; if (iwait !== 1'b1 || ramREN !== 1'b0) begin failures++; $display("FAIL t1_idle got=iwait%0b ren%0b exp=iwait1 ren0", iwait, ramREN); end
    @(negedge CLK); ramstate = BUSY; #1;
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h40) begin failures++; $display("FAIL t1_gnt got=ren%0b addr%h exp=ren1 addr40", ramREN, ramaddr); end
    checks++; if (iwait !== 1'b1) begin failures++; $display("FAIL t1_busy1 got=%0b exp=1", iwait); end
    @(negedge CLK); ramstate = BUSY; #1;
    checks++; if (iwait !== 1'b1) begin failures++; $display("FAIL t1_busy2 got=%0b exp=1", iwait); end
    @(negedge CLK); ramstate = ACCESS; ramload = 32'hDEADBEEF; #1;
    checks++; if (iwait !== 1'b0 || iload !== 32'hDEADBEEF) begin failures++; $display("FAIL t1_done got=iwait%0b load%h exp=iwait0 loadDEADBEEF", iwait, iload); end
    @(negedge CLK); iREN = 0; ramstate = FREE; #1;
    checks++; if (ramREN !== 1'b0 || o_dbg_state !== 2'd0) begin failures++; $display("FAIL t1_after got=ren%0b st%0d exp=ren0 st0", ramREN, o_dbg_state); end
  endtask

  task automatic test_priority();
    @(negedge CLK); iREN = 1; iaddr = 32'h80; dWEN = 1; daddr = 32'h100; dstore = 32'h5; ramstate = FREE; #1;
    checks++; if (iwait !== 1'b1 || dwait !== 1'b1) begin failures++; $display("FAIL t2_idle got=%0b%0b exp=11", iwait, dwait); end
    @(negedge CLK); ramstate = BUSY; #1;
    checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h100 || ramstore !== 32'h5) begin failures++; $display("FAIL t2_dgnt got=wen%0b ren%0b addr%h st%h exp=wen1 ren0 addr100 st5", ramWEN, ramREN, ramaddr, ramstore); end
    checks++; if (iwait !== 1'b1) begin failures++; $display("FAIL t2_iwait_busy got=%0b exp=1", iwait); end
    @(negedge CLK); ramstate = ACCESS; #1;
    checks++; if (dwait !== 1'b0 || iwait !== 1'b1) begin failures++; $display("FAIL t2_ddone got=dwait%0b iwait%0b exp=dwait0 iwait1", dwait, iwait); end
    @(negedge CLK); dWEN = 0; ramstate = FREE; #1;
    checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || iwait !== 1'b1) begin failures++; $display("FAIL t2_idle2 got=ren%0b wen%0b iwait%0b exp=0 0 1", ramREN, ramWEN, iwait); end
    @(negedge CLK); ramstate = ACCESS; ramload = 32'h1234; #1;
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h80 || iwait !== 1'b0 || iload !== 32'h1234) begin failures++; $display("FAIL t2_idone got=ren%0b addr%h iwait%0b load%h exp=1 80 0 1234", ramREN, ramaddr, iwait, iload); end
    @(negedge CLK); iREN = 0; ramstate = FREE;
  endtask

  task automatic test_error();
    @(negedge CLK); dREN = 1; daddr = 32'h20; ramstate = FREE; #1;
    @(negedge CLK); ramstate = ERROR; #1;
    checks++; if (ramREN !== 1'b1 || dwait !== 1'b1 || memerr !== 1'b0) begin failures++; $display("FAIL t4_err got=ren%0b dwait%0b memerr%0b exp=1 1 0", ramREN, dwait, memerr); end
    @(negedge CLK); ramstate = ACCESS; #1;
    checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || dwait !== 1'b1 || memerr !== 1'b1) begin failures++; $display("FAIL t4_idle got=ren%0b wen%0b dwait%0b memerr%0b exp=0 0 1 1", ramREN, ramWEN, dwait, memerr); end
    @(negedge CLK); ramstate = ACCESS; ramload = 32'hCAFE; #1;
    checks++; if (dwait !== 1'b0 || dload !== 32'hCAFE) begin failures++; $display("FAIL t4_retry got=dwait%0b load%h exp=dwait0 loadCAFE", dwait, dload); end
    @(negedge CLK); dREN = 0; ramstate = FREE; #1;
    checks++; if (memerr !== 1'b1) begin failures++; $display("FAIL t4_sticky got=%0b exp=1", memerr); end
  endtask

  task automatic test_reset_mid();
    @(negedge CLK); iREN = 1; iaddr = 32'h44; ramstate = FREE; #1;
    @(negedge CLK); ramstate = BUSY; #1;
    checks++; if (ramREN !== 1'b1) begin failures++; $display("FAIL t5_pre got=%0b exp=1", ramREN); end
    #1 RST = 1'b1; #1;
    checks++; if (ramREN !== 1'b0 || o_dbg_state !== 2'd0 || memerr !== 1'b0) begin failures++; $display("FAIL t5_async got=ren%0b st%0d memerr%0b exp=0 0 0", ramREN, o_dbg_state, memerr); end
    iREN = 0;
    @(negedge CLK); RST = 1'b0; ramstate = FREE;
  endtask

  task automatic test_abort();
    @(negedge CLK); iREN = 1; iaddr = 32'h48; dREN = 1; daddr = 32'h24; ramstate = FREE; #1;
    @(negedge CLK); ramstate = BUSY; #1;
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h24) begin failures++; $display("FAIL t6_dgnt got=ren%0b addr%h exp=1 24", ramREN, ramaddr); end
    @(negedge CLK); dREN = 0; ramstate = BUSY; #1;
    checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || dwait !== 1'b0 || dload !== '0) begin failures++; $display("FAIL t6_abort got=ren%0b wen%0b dwait%0b load%h exp=0 0 0 0", ramREN, ramWEN, dwait, dload); end
    @(negedge CLK); ramstate = FREE; #1;
    checks++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin failures++; $display("FAIL t6_idle got=ren%0b iwait%0b exp=0 1", ramREN, iwait); end
    @(negedge CLK); ramstate = ACCESS; ramload = 32'h77; #1;
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h48 || iwait !== 1'b0 || iload !== 32'h77) begin failures++; $display("FAIL t6_igrant got=ren%0b addr%h iwait%0b load%h exp=1 48 0 77", ramREN, ramaddr, iwait, iload); end
    @(negedge CLK); iREN = 0; ramstate = FREE;
  endtask

  // Both sides hold requests and the RAM answers at once: data may win at most
  // D_STREAK_MAX times in a row before the fetch is served.
  task automatic test_streak();
    logic [7:0] exp_q[$];
    logic [7:0] got;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < D_STREAK_MAX; k++) exp_q.push_back(8'hD0);
      exp_q.push_back(8'h10);
    end
    for (int c = 0; c < 2 * (D_STREAK_MAX + 1) * 3; c++) begin
      @(negedge CLK); iREN = 1; iaddr = 32'h60; dREN = 1; daddr = 32'h30; ramstate = ACCESS;
      ramload = 32'hA0 + 32'(c); #1;
      if (!iwait || !dwait) begin
        got = !iwait ? 8'h10 : 8'hD0;
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL t3_extra got=%h exp=none", got); end
        else if (got !== exp_q[0]) begin failures++; $display("FAIL t3_order got=%h exp=%h", got, exp_q[0]); void'(exp_q.pop_front()); end
        else void'(exp_q.pop_front());
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL t3_missing got=%0d left exp=0", exp_q.size()); end
    @(negedge CLK); iREN = 0; dREN = 0; ramstate = FREE;
    @(negedge CLK);
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] mem [16];
    logic [DATA_W-1:0] ref_mem [16];
    bit i_act, d_act, i_done, d_done, d_wr, ok;
    int i_age, d_age, streak;
    i_act = 0; d_act = 0; i_done = 0; d_done = 0; d_wr = 0; i_age = 0; d_age = 0; streak = 0;
    for (int k = 0; k < 16; k++) begin mem[k] = $urandom; ref_mem[k] = mem[k]; end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge CLK);
      if (i_done) begin iREN = 0; i_act = 0; i_done = 0; end
      else if (!i_act && $urandom_range(0, 2) == 0) begin
        i_act = 1; i_age = 0; iREN = 1; iaddr = ADDR_W'($urandom_range(0, 15) * 4);
      end
      if (d_done) begin dREN = 0; dWEN = 0; d_act = 0; d_done = 0; end
      else if (!d_act && $urandom_range(0, 1) == 0) begin
        d_act = 1; d_age = 0; d_wr = 1'($urandom_range(0, 1));
        dWEN = d_wr; dREN = d_wr ? 1'($urandom_range(0, 1)) : 1'b1;
        daddr = ADDR_W'($urandom_range(0, 15) * 4); dstore = $urandom;
      end
      #1;
      if (ramREN || ramWEN) ramstate = ($urandom_range(0, 2) == 0) ? ACCESS : BUSY;
      else ramstate = FREE;
      ramload = mem[ramaddr[5:2]];
      #1;
      checks++; if (ramREN && ramWEN) begin failures++; $display("FAIL r_strobe_excl got=11 exp=one"); end
      if (ramREN || ramWEN) begin
        ok = (ramWEN && !ramREN && d_act && dWEN && ramaddr == daddr && ramstore == dstore) ||
             (ramREN && !ramWEN && ((i_act && ramaddr == iaddr) || (d_act && !dWEN && ramaddr == daddr)));
        checks++; if (!ok) begin failures++; $display("FAIL r_ram_fwd got=ren%0b wen%0b addr%h exp=owner request cyc%0d", ramREN, ramWEN, ramaddr, cyc); end
      end
      if (i_act) begin
        if (!iwait) begin
          checks++; if (ramstate !== ACCESS) begin failures++; $display("FAIL r_i_early got=%0d exp=2", ramstate); end
          checks++; if (iload !== ref_mem[iaddr[5:2]]) begin failures++; $display("FAIL r_iload got=%h exp=%h", iload, ref_mem[iaddr[5:2]]); end
          streak = 0; i_done = 1;
        end else if (++i_age > 200) begin
          checks++; failures++; $display("FAIL r_i_timeout got=%0d cycles exp<=200", i_age); i_done = 1;
        end
      end else begin
        checks++; if (iwait !== 1'b0 || iload !== '0) begin failures++; $display("FAIL r_i_idle got=wait%0b load%h exp=0 0", iwait, iload); end
      end
      if (d_act) begin
        if (!dwait) begin
          checks++; if (ramstate !== ACCESS) begin failures++; $display("FAIL r_d_early got=%0d exp=2", ramstate); end
          if (!d_wr) begin
            checks++; if (dload !== ref_mem[daddr[5:2]]) begin failures++; $display("FAIL r_dload got=%h exp=%h", dload, ref_mem[daddr[5:2]]); end
          end else ref_mem[daddr[5:2]] = dstore;
          if (i_act) begin
            checks++; if (streak >= D_STREAK_MAX) begin failures++; $display("FAIL r_starve got=%0d exp<%0d", streak, D_STREAK_MAX); end
            streak++;
          end else streak = 0;
          d_done = 1;
        end else if (++d_age > 200) begin
          checks++; failures++; $display("FAIL r_d_timeout got=%0d cycles exp<=200", d_age); d_done = 1;
        end
      end else begin
        checks++; if (dwait !== 1'b0) begin failures++; $display("FAIL r_d_idle got=%0b exp=0", dwait); end
      end
      if (ramWEN && ramstate == ACCESS) mem[ramaddr[5:2]] = ramstore;
    end
    @(negedge CLK); iREN = 0; dREN = 0; dWEN = 0; ramstate = FREE;
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_instr_fetch();
    test_priority();
    test_error();
    test_reset_mid();
    test_abort();
    test_streak();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
